// File: rtl/shift_reg_sipo_if.sv
// Bundle for the serial-in / parallel-out deserializer: the serial input side,
// the parallel output handshake and the status signals.
interface shift_reg_sipo_if #(
  parameter int size = 8
);
  localparam int CW = $clog2(size);

  logic            datain;
  logic            din_valid;
  logic            sync;
  logic [size-1:0] dataout;
  logic            dout_valid;
  logic            dout_ready;
  logic            overrun;
  logic            overrun_clr;
  logic [CW-1:0]   bit_cnt;

  // Producer/consumer side: drives serial bits, accepts words.
  modport master (
    output datain, din_valid, sync, dout_ready, overrun_clr,
    input  dataout, dout_valid, overrun, bit_cnt
  );

  // Deserializer side.
  modport slave (
    input  datain, din_valid, sync, dout_ready, overrun_clr,
    output dataout, dout_valid, overrun, bit_cnt
  );
endinterface

// File: rtl/shift_reg_sipo.sv
// Serial-in parallel-out deserializer. Collects qualified serial bits into a
// size-bit word, presents each completed word on a registered output with a
// valid/ready handshake, supports frame resync and flags dropped words.
module shift_reg_sipo #(
  parameter int size      = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  shift_reg_sipo_if.slave  bus
);
  localparam int            CW   = $clog2(size);
  localparam logic [CW-1:0] LAST = CW'(size - 1);

  logic [size-1:0] sr;
  logic [size-1:0] sr_shift;
  logic [size-1:0] dout_q;
  logic            dvalid_q;
  logic            ovr_q;
  logic [CW-1:0]   cnt_q;
  logic            complete;
  logic            accept;
  logic            drop;

  // Shifted value including the current bit, plus handshake qualifiers.
  always_comb begin
    sr_shift = '0;
    if (MSB_FIRST) sr_shift = {sr[size-2:0], bus.datain};
    else           sr_shift = {bus.datain, sr[size-1:1]};
    accept   = dvalid_q & bus.dout_ready;
    complete = bus.din_valid & ~bus.sync & (cnt_q == LAST);
    drop     = complete & dvalid_q & ~bus.dout_ready;
  end

  // Shift register and bit counter; a sync restarts the word count, and any
  // leftover bits in sr are pushed out before that new word completes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr    <= '0;
      cnt_q <= '0;
    end else begin
      if (bus.din_valid) sr <= sr_shift;
      if (bus.sync)
        cnt_q <= bus.din_valid ? CW'(1) : '0;
      else if (bus.din_valid)
        cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // Output word register, valid flag and sticky overrun.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      if (complete && (!dvalid_q || accept)) begin
        dout_q   <= sr_shift;
        dvalid_q <= 1'b1;
      end else if (accept) begin
        dvalid_q <= 1'b0;
      end
      if (drop)                 ovr_q <= 1'b1;
      else if (bus.overrun_clr) ovr_q <= 1'b0;
    end
  end

  assign bus.dataout    = dout_q;
  assign bus.dout_valid = dvalid_q;
  assign bus.overrun    = ovr_q;
  assign bus.bit_cnt    = cnt_q;
endmodule

// File: tb/tb_shift_reg_sipo.sv
// Directed bench for shift_reg_sipo: one MSB-first and one LSB-first instance
// fed the same serial stream and handshake signals.
module tb_shift_reg_sipo;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic datain = 1'b0;
  logic din_valid = 1'b0;
  logic sync = 1'b0;
  logic dout_ready = 1'b1;
  logic overrun_clr = 1'b0;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  shift_reg_sipo_if #(.size(8)) ifm ();
  shift_reg_sipo_if #(.size(8)) ifl ();

  assign ifm.datain      = datain;
  assign ifm.din_valid   = din_valid;
  assign ifm.sync        = sync;
  assign ifm.dout_ready  = dout_ready;
  assign ifm.overrun_clr = overrun_clr;
  assign ifl.datain      = datain;
  assign ifl.din_valid   = din_valid;
  assign ifl.sync        = sync;
  assign ifl.dout_ready  = dout_ready;
  assign ifl.overrun_clr = overrun_clr;

  shift_reg_sipo #(.size(8), .MSB_FIRST(1'b1)) dut_msb (
    .clk(clk), .reset(reset), .bus(ifm)
  );
  shift_reg_sipo #(.size(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .bus(ifl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock edge; sampling happens 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    datain    = b;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
  endtask

  // Bits go out w[7] first.
  task automatic send_word(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  initial begin
    logic [7:0] w;
    // Test 1: reset, then 8'hDD MSB first on both instances.
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_dataout", ifm.dataout, 32'h0);
    check("rst_dout_valid", ifm.dout_valid, 32'h0);
    check("rst_overrun", ifm.overrun, 32'h0);
    check("rst_bit_cnt", ifm.bit_cnt, 32'h0);
    reset = 1'b1;
    tick();
    w = 8'b1101_1101;
    for (int i = 7; i >= 1; i--) send_bit(w[i]);
    check("t1_cnt7", ifm.bit_cnt, 32'd7);
    check("t1_valid_pre", ifm.dout_valid, 32'h0);
    send_bit(w[0]);
    check("t1_dataout", ifm.dataout, 32'hDD);
    check("t1_valid", ifm.dout_valid, 32'h1);
    check("t1_cnt0", ifm.bit_cnt, 32'h0);
    // Test 2: LSB-first instance saw the same bits.
    check("t2_dataout_lsb", ifl.dataout, 32'hBB);
    check("t2_valid_lsb", ifl.dout_valid, 32'h1);
    tick();
    check("t1_accept", ifm.dout_valid, 32'h0);
    check("t1_hold", ifm.dataout, 32'hDD);

    // Test 3: consumer stalled, second word dropped.
    dout_ready = 1'b0;
    send_word(8'hDD);
    check("t3_valid1", ifm.dout_valid, 32'h1);
    check("t3_ovr0", ifm.overrun, 32'h0);
    send_word(8'h3C);
    check("t3_dataout", ifm.dataout, 32'hDD);
    check("t3_valid2", ifm.dout_valid, 32'h1);
    check("t3_ovr1", ifm.overrun, 32'h1);
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    check("t3_ovr_clr", ifm.overrun, 32'h0);
    check("t3_still_valid", ifm.dout_valid, 32'h1);
    dout_ready = 1'b1;
    tick();
    check("t3_drain", ifm.dout_valid, 32'h0);

    // Test 4: two idle cycles after every bit.
    w = 8'hDD;
    for (int i = 7; i >= 1; i--) begin
      send_bit(w[i]);
      repeat (2) tick();
      check("t4_gap_cnt", ifm.bit_cnt, 32'(8 - i));
    end
    check("t4_valid_pre", ifm.dout_valid, 32'h0);
    send_bit(w[0]);
    check("t4_dataout", ifm.dataout, 32'hDD);
    check("t4_valid", ifm.dout_valid, 32'h1);
    tick();

    // Test 5: junk bits, then sync on the first bit of 8'hA5.
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    check("t5_junk_cnt", ifm.bit_cnt, 32'd3);
    w = 8'hA5;
    sync = 1'b1;
    send_bit(w[7]);
    sync = 1'b0;
    check("t5_sync_cnt", ifm.bit_cnt, 32'd1);
    for (int i = 6; i >= 1; i--) send_bit(w[i]);
    check("t5_no_early_word", ifm.dout_valid, 32'h0);
    send_bit(w[0]);
    check("t5_dataout", ifm.dataout, 32'hA5);
    check("t5_dataout_lsb", ifl.dataout, 32'hA5);
    check("t5_valid", ifm.dout_valid, 32'h1);
    check("t5_no_ovr", ifm.overrun, 32'h0);
    tick();

    // Sync on the would-be last bit suppresses the word.
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    sync = 1'b1;
    send_bit(1'b0);
    check("t5b_no_word", ifm.dout_valid, 32'h0);
    check("t5b_cnt1", ifm.bit_cnt, 32'd1);
    tick();
    sync = 1'b0;
    check("t5b_cnt0", ifm.bit_cnt, 32'h0);
    check("t5b_dataout_kept", ifm.dataout, 32'hA5);

    // Test 6: async reset mid-word, then a clean word.
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    check("t6_cnt5", ifm.bit_cnt, 32'd5);
    reset = 1'b0;
    #1;
    check("t6_rst_dataout", ifm.dataout, 32'h0);
    check("t6_rst_valid", ifm.dout_valid, 32'h0);
    check("t6_rst_cnt", ifm.bit_cnt, 32'h0);
    check("t6_rst_ovr", ifm.overrun, 32'h0);
    #2 reset = 1'b1;
    tick();
    send_word(8'h5A);
    check("t6_dataout", ifm.dataout, 32'h5A);
    check("t6_dataout_lsb", ifl.dataout, 32'h5A);
    check("t6_valid", ifm.dout_valid, 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
